// File: rtl/spiflash_responder.sv
// spiflash_responder: read-only SPI/QSPI flash target (0x03, 0xEB, continuous read).
// SCK/CSn/D are oversampled in the clk domain; data bytes are fetched one at a time
// from a backing memory over mem_addr/mem_rd/mem_rdata.
// Ports: clk, rst_n | flash_clk, flash_csn, flash_d_i[3:0] -> flash_d_o[3:0],
//        flash_d_oe[3:0] | mem_addr[23:0], mem_rd -> mem_rdata[7:0].
module spiflash_responder #(
    parameter int CLK_RATIO_MIN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flash_clk,
    input  logic        flash_csn,
    input  logic [3:0]  flash_d_i,
    output logic [3:0]  flash_d_o,
    output logic [3:0]  flash_d_oe,
    output logic [23:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, MODE, DUMMY, DATA, IGNORE
    } state_t;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_QREAD = 8'hEB;

    // The fetched byte is loaded one clk after mem_rd, which must land
    // before the following SCK fall.
    if (CLK_RATIO_MIN < 2) begin : g_ratio_chk
        $error("CLK_RATIO_MIN must be at least 2");
    end

    state_t state, state_n;

    logic        sck_m, sck_s, sck_q;
    logic        csn_m, csn_s, csn_q;
    logic [3:0]  d_m, d_s;

    logic [4:0]  bit_cnt;
    logic [22:0] shift_in;
    logic [7:0]  shift_out;
    logic        quad;
    logic        cont_mode;
    logic [3:0]  d_o_q;

    logic        sck_rise, sck_fall, csn_fall;
    logic        phase_end, last_rise, in_quad;
    logic [7:0]  cmd_byte;
    logic [23:0] addr_word;

    // Synchronizers. CSn resets low so that a CSn already low when reset
    // is released never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_m <= 1'b0;
            sck_s <= 1'b0;
            sck_q <= 1'b0;
            csn_m <= 1'b0;
            csn_s <= 1'b0;
            csn_q <= 1'b0;
            d_m   <= '0;
            d_s   <= '0;
        end else begin
            sck_m <= flash_clk;
            sck_s <= sck_m;
            sck_q <= sck_s;
            csn_m <= flash_csn;
            csn_s <= csn_m;
            csn_q <= csn_s;
            d_m   <= flash_d_i;
            d_s   <= d_m;
        end
    end

    assign sck_rise  = sck_s & ~sck_q;
    assign sck_fall  = ~sck_s & sck_q;
    assign csn_fall  = ~csn_s & csn_q;
    assign last_rise = sck_rise & phase_end;
    assign in_quad   = (state == MODE) ||
                       ((state == ADDR) && quad);
    assign cmd_byte  = {shift_in[6:0], d_s[0]};
    assign addr_word = quad ? {shift_in[19:0], d_s}
                            : {shift_in[22:0], d_s[0]};

    always_comb begin
        phase_end = 1'b0;
        unique case (state)
            CMD:     phase_end = (bit_cnt == 5'd7);
            ADDR:    phase_end = quad ? (bit_cnt == 5'd5)
                                      : (bit_cnt == 5'd23);
            MODE:    phase_end = (bit_cnt == 5'd1);
            DUMMY:   phase_end = (bit_cnt == 5'd3);
            DATA:    phase_end = quad ? (bit_cnt == 5'd1)
                                      : (bit_cnt == 5'd7);
            default: phase_end = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        if ((state != IDLE) && csn_s) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (csn_fall)
                        state_n = cont_mode ? ADDR : CMD;
                end
                CMD: begin
                    if (last_rise) begin
                        if ((cmd_byte == CMD_READ) ||
                            (cmd_byte == CMD_QREAD))
                            state_n = ADDR;
                        else
                            state_n = IGNORE;
                    end
                end
                ADDR: begin
                    if (last_rise)
                        state_n = quad ? MODE : DATA;
                end
                MODE: begin
                    if (last_rise) state_n = DUMMY;
                end
                DUMMY: begin
                    if (last_rise) state_n = DATA;
                end
                DATA:    state_n = DATA;
                IGNORE:  state_n = IGNORE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift_in  <= '0;
            shift_out <= '0;
            quad      <= 1'b0;
            cont_mode <= 1'b0;
            d_o_q     <= '0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
        end else begin
            mem_rd <= 1'b0;
            if (csn_s || (state == IDLE)) begin
                bit_cnt <= '0;
                d_o_q   <= '0;
                // Continuous mode survives only if the mode byte was seen.
                if (csn_s && ((state == CMD) || (state == ADDR) ||
                              (state == MODE)))
                    cont_mode <= 1'b0;
                if ((state == IDLE) && csn_fall)
                    quad <= cont_mode;
            end else if (state != IGNORE) begin
                if (sck_rise) begin
                    bit_cnt  <= phase_end ? '0 : bit_cnt + 5'd1;
                    shift_in <= in_quad ? {shift_in[18:0], d_s}
                                        : {shift_in[21:0], d_s[0]};
                end
                if (last_rise) begin
                    unique case (state)
                        CMD: quad <= (cmd_byte == CMD_QREAD);
                        ADDR: begin
                            mem_addr <= addr_word;
                            mem_rd   <= ~quad;
                        end
                        // mode[5:4] are the low bits of the first nibble
                        MODE:  cont_mode <= (shift_in[1:0] == 2'b10);
                        DUMMY: mem_rd <= 1'b1;
                        DATA: begin
                            mem_addr <= mem_addr + 24'd1;
                            mem_rd   <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                if (sck_fall && (state == DATA)) begin
                    d_o_q <= quad ? shift_out[7:4]
                                  : {2'b00, shift_out[7], 1'b0};
                    shift_out <= quad ? {shift_out[3:0], 4'h0}
                                      : {shift_out[6:0], 1'b0};
                end
            end
            if (mem_rd) shift_out <= mem_rdata;
        end
    end

    always_comb begin
        flash_d_oe = 4'b0000;
        if (state == DATA)
            flash_d_oe = quad ? 4'b1111 : 4'b0010;
    end

    assign flash_d_o = d_o_q;

endmodule

// File: tb/tb_spiflash_responder.sv
// tb_spiflash_responder: directed SPI/QSPI controller driving spiflash_responder,
// checked against a transaction-level model of the expected bit stream and reads.
module tb_spiflash_responder;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flash_clk = 1'b0;
    logic        flash_csn = 1'b1;
    logic [3:0]  flash_d_i = 4'h0;
    logic [3:0]  flash_d_o;
    logic [3:0]  flash_d_oe;
    logic [23:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [23:0] rd_exp[$];
    logic [23:0] rd_log[$];
    bit          model_cont = 1'b0;
    bit          chk_en = 1'b0;
    bit          chk_rst = 1'b0;
    logic [3:0]  exp_oe = 4'h0;
    logic [3:0]  exp_do = 4'h0;

    always #5 clk = ~clk;

    spiflash_responder #(.CLK_RATIO_MIN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flash_clk (flash_clk),
        .flash_csn (flash_csn),
        .flash_d_i (flash_d_i),
        .flash_d_o (flash_d_o),
        .flash_d_oe(flash_d_oe),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'hA5;
            24'h000101: return 8'h3C;
            24'h123456: return 8'h9E;
            default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
        endcase
    endfunction

    // Backing memory: data valid at the clk edge that closes the mem_rd cycle.
    assign mem_rdata = mem_rd ? mem_byte(mem_addr) : 8'h00;

    always @(negedge clk) begin : cmp
        logic [23:0] e;
        if (mem_rd === 1'b1) begin
            checks++;
            rd_log.push_back(mem_addr);
            if (rd_exp.size() == 0) begin
                errors++;
                $display("FAIL mem_rd_extra: addr=%06h, no read expected",
                         mem_addr);
            end else begin
                e = rd_exp.pop_front();
                if (mem_addr !== e) begin
                    errors++;
                    $display("FAIL mem_addr: got=%06h want=%06h",
                             mem_addr, e);
                end
            end
        end
        if (chk_en) begin
            checks++;
            if ((flash_d_oe !== exp_oe) || (flash_d_o !== exp_do)) begin
                errors++;
                $display("FAIL pins: oe=%b do=%b want oe=%b do=%b t=%0t",
                         flash_d_oe, flash_d_o, exp_oe, exp_do, $time);
            end
        end
        if (chk_rst) begin
            checks++;
            if ((mem_addr !== 24'h0) || (mem_rd !== 1'b0)) begin
                errors++;
                $display("FAIL reset_mem: addr=%06h rd=%b want 000000/0",
                         mem_addr, mem_rd);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pins(input logic [3:0] oe, input logic [3:0] d_o);
        exp_oe = oe;
        exp_do = d_o;
        chk_en = 1'b1;
        tick();
        chk_en = 1'b0;
    endtask

    task automatic check_val(input string name, input logic [31:0] got,
                             input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    // One SCK pulse: data set after the fall, pins checked just before rise.
    task automatic sck_cycle(input logic [3:0] din, input logic [3:0] oe,
                             input logic [3:0] d_o, output logic [3:0] seen);
        flash_d_i = din;
        repeat (HALF - 1) tick();
        seen = flash_d_o;
        expect_pins(oe, d_o);
        flash_clk = 1'b1;
        repeat (HALF) tick();
        flash_clk = 1'b0;
    endtask

    task automatic send_field(input logic [23:0] v, input int nbits,
                              input bit q);
        logic [3:0] seen;
        if (q) begin
            for (int i = nbits / 4 - 1; i >= 0; i--)
                sck_cycle(4'(v >> (4 * i)), 4'h0, 4'h0, seen);
        end else begin
            for (int i = nbits - 1; i >= 0; i--)
                sck_cycle({3'b000, v[i]}, 4'h0, 4'h0, seen);
        end
    endtask

    task automatic read_data(input logic [23:0] a, input bit q,
                             input int nunits, output logic [15:0] got);
        logic [3:0] seen;
        logic [7:0] b;
        logic [3:0] e;
        int per;
        per = q ? 2 : 8;
        got = 16'h0;
        for (int i = 0; i < nunits; i++) begin
            b = mem_byte(a + 24'(i / per));
            if (q) e = ((i % 2) == 0) ? b[7:4] : b[3:0];
            else   e = {2'b00, b[7 - (i % 8)], 1'b0};
            if ((i % per) == per - 1)
                rd_exp.push_back(a + 24'(i / per + 1));
            sck_cycle(4'h0, q ? 4'hF : 4'h2, e, seen);
            got = q ? {got[11:0], seen} : {got[14:0], seen[1]};
        end
    endtask

    task automatic cs_low(input bit with_sck);
        flash_csn = 1'b0;
        if (with_sck) begin
            flash_clk = 1'b1;
            repeat (HALF) tick();
            flash_clk = 1'b0;
        end
        repeat (HALF) tick();
    endtask

    task automatic cs_high();
        flash_csn = 1'b1;
        repeat (3) tick();
        expect_pins(4'h0, 4'h0);
        repeat (HALF) tick();
        check_val("rd_missing", rd_exp.size(), 0);
        rd_exp.delete();
    endtask

    task automatic read03(input logic [23:0] a, input int nbits,
                          input bit edge_cs, output logic [15:0] got);
        cs_low(edge_cs);
        send_field(24'h000003, 8, 1'b0);
        rd_exp.push_back(a);
        send_field(a, 24, 1'b0);
        read_data(a, 1'b0, nbits, got);
        cs_high();
    endtask

    task automatic read_eb(input logic [23:0] a, input logic [7:0] mode,
                           input int nnib, output logic [15:0] got);
        cs_low(1'b0);
        if (!model_cont) send_field(24'h0000EB, 8, 1'b0);
        send_field(a, 24, 1'b1);
        send_field({16'h0, mode}, 8, 1'b1);
        rd_exp.push_back(a);
        send_field(24'h0, 16, 1'b1);
        read_data(a, 1'b1, nnib, got);
        cs_high();
        model_cont = (mode[5:4] == 2'b10);
    endtask

    initial begin
        logic [15:0] got;
        logic [3:0]  seen;

        chk_rst = 1'b1;
        repeat (3) expect_pins(4'h0, 4'h0);
        chk_rst = 1'b0;
        rst_n = 1'b1;
        repeat (4) tick();

        // SCK activity with CSn high must be ignored
        repeat (3) sck_cycle(4'hF, 4'h0, 4'h0, seen);

        rd_log.delete();
        read03(24'h000100, 16, 1'b0, got);
        check_val("read03_bits", got, 16'hA53C);
        check_val("read03_nrd", rd_log.size(), 3);
        if (rd_log.size() >= 2) begin
            check_val("read03_rd0", rd_log[0], 24'h000100);
            check_val("read03_rd1", rd_log[1], 24'h000101);
        end

        read_eb(24'h123456, 8'h00, 2, got);
        check_val("readeb_nib", got[7:0], 8'h9E);

        read_eb(24'h000200, 8'hA0, 2, got);
        read_eb(24'h000010, 8'hA0, 4, got);
        check_val("cont_data", got, 16'h4A4B);
        read_eb(24'h000020, 8'hA0, 2, got);
        read_eb(24'h000030, 8'hFF, 2, got);
        read03(24'h000040, 8, 1'b0, got);
        check_val("after_ff", got[7:0], 8'h1A);

        // CSn rising during the address of a continuous read drops cont_mode
        read_eb(24'h000050, 8'hA0, 2, got);
        cs_low(1'b0);
        send_field(24'h000000, 12, 1'b1);
        cs_high();
        model_cont = 1'b0;
        read03(24'h000070, 8, 1'b0, got);
        check_val("after_abort", got[7:0], 8'h2A);

        rd_log.delete();
        read03(24'hFFFFFF, 16, 1'b1, got);
        check_val("wrap_bits", got, 16'hA55A);
        if (rd_log.size() >= 2) begin
            check_val("wrap_rd0", rd_log[0], 24'hFFFFFF);
            check_val("wrap_rd1", rd_log[1], 24'h000000);
        end else begin
            check_val("wrap_nrd", rd_log.size(), 3);
        end

        cs_low(1'b0);
        send_field(24'h00009F, 8, 1'b0);
        repeat (32) sck_cycle(4'hF, 4'h0, 4'h0, seen);
        cs_high();

        cs_low(1'b0);
        send_field(24'h000003, 8, 1'b0);
        rd_exp.push_back(24'h000300);
        send_field(24'h000300, 24, 1'b0);
        read_data(24'h000300, 1'b0, 5, got);
        cs_high();

        cs_low(1'b0);
        send_field(24'h000003, 8, 1'b0);
        rd_exp.push_back(24'h000400);
        send_field(24'h000400, 24, 1'b0);
        read_data(24'h000400, 1'b0, 3, got);
        rst_n = 1'b0;
        chk_rst = 1'b1;
        repeat (3) expect_pins(4'h0, 4'h0);
        flash_csn = 1'b1;
        repeat (2) expect_pins(4'h0, 4'h0);
        chk_rst = 1'b0;
        rd_exp.delete();
        rst_n = 1'b1;
        repeat (HALF) tick();
        read03(24'h000400, 16, 1'b0, got);
        check_val("post_reset", got, 16'h5E5F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spiflash_responder.md
SPIFLASH_RESPONDER -- requirements
Module: spiflash_responder

Interface
REQ-001 clk  input  1  system clock; all state on rising edge; SCK, CSn, D oversampled in this domain.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 flash_clk  input  1  SPI SCK from controller, mode 0, idle low.
REQ-004 flash_csn  input  1  chip select, active-low.
REQ-005 flash_d_i  input  4  controller-driven data lines D[3:0].
REQ-006 flash_d_o  output  4  responder-driven data lines.
REQ-007 flash_d_oe  output  4  per-line output enable, 1 = responder drives.
REQ-008 mem_addr  output  24  byte address to backing memory.
REQ-009 mem_rd  output  1  one-clk read strobe; mem_addr valid while high.
REQ-010 mem_rdata  input  8  read data, valid at the first clk edge after mem_rd.
REQ-011 Parameter CLK_RATIO_MIN, default 4: minimum SCK high and low time in clk periods supported.

Function
REQ-012 flash_clk, flash_csn, flash_d_i each pass through a 2-flop synchronizer; all edge detection uses synchronized values.
REQ-013 Sampling on synchronized SCK rise; output updates on synchronized SCK fall; MSB first; quad phases carry high nibble first.
REQ-014 States: IDLE, CMD, ADDR, MODE, DUMMY, DATA, IGNORE.
REQ-015 IDLE -> CMD on CSn falling; IDLE -> ADDR instead when cont_mode = 1.
REQ-016 CMD: 8 bits on D[0]; 0x03 -> ADDR single; 0xEB -> ADDR quad; any other value (incl. 0xAB) -> IGNORE.
REQ-017 ADDR single: 24 bits on D[0] (24 SCK); quad: 24 bits on D[3:0] (6 SCK).
REQ-018 0x03: ADDR -> DATA, no mode, no dummy.
REQ-019 0xEB: ADDR -> MODE (8 bits, 2 quad SCK) -> DUMMY (4 SCK) -> DATA.
REQ-020 cont_mode set at end of MODE iff mode[5:4] = 2'b10, else cleared; continuous transaction behaves as 0xEB from ADDR onward.
REQ-021 mem_rd pulses once on the SCK rise completing ADDR (0x03) or DUMMY (0xEB), and on the SCK rise completing each data byte; captured byte loaded into shift register before the next SCK fall.
REQ-022 mem_addr = received address for first byte, then +1 per byte; 24-bit wrap 0xFFFFFF -> 0x000000.
REQ-023 DATA single: flash_d_oe = 4'b0010, bit on flash_d_o[1], others 0; quad: flash_d_oe = 4'b1111.
REQ-024 First data bit driven after the SCK fall following the last ADDR (0x03) or DUMMY (0xEB) SCK; flash_d_oe = 0 in all states except DATA.
REQ-025 DATA continues indefinitely until CSn high; IGNORE holds outputs disabled until CSn high.
REQ-026 Synchronized CSn high in any state -> IDLE within 1 clk: flash_d_oe = 0, bit counters cleared; cont_mode cleared if CSn rises before MODE completes, else retained.
REQ-027 SCK edges while CSn high ignored; CSn fall coincident with an SCK edge: edge ignored.

Reset
REQ-028 While rst_n low: state IDLE, flash_d_o = 0, flash_d_oe = 0, mem_addr = 0, mem_rd = 0, cont_mode = 0, shift/bit counters 0.
REQ-029 Reset mid-transaction aborts it; after release, responder waits for a fresh CSn falling edge.

Verification
REQ-030 0x03, addr 0x000100, mem[0x100..0x101] = 0xA5,0x3C, 16 SCK -> D[1] bits 1010_0101_0011_1100, mem_rd pulses with addr 0x100 then 0x101, d_oe = 0010.
REQ-031 0xEB, addr 0x123456, mode 0x00, 4 dummy, mem[0x123456] = 0x9E -> nibbles 0x9 then 0xE, d_oe = 1111 only in DATA, cont_mode = 0.
REQ-032 0xEB with mode 0xA0, CSn high, new CSn low, quad addr 0x000010 -> no CMD phase, data from 0x10 after mode + 4 dummy; cont_mode = 1 retained until a later mode 0xFF.
REQ-033 0x03 at 0xFFFFFF, 2 bytes -> mem_addr 0xFFFFFF then 0x000000.
REQ-034 Command 0x9F -> d_oe stays 0 for 32 further SCK, no mem_rd; CSn raised mid-DATA of a 0x03 read -> d_oe = 0 within 3 clk.
REQ-035 rst_n low during DATA -> d_oe = 0 immediately (async); next 0x03 transaction after release returns correct data.
